// File: rtl/receiver_pkg.sv
// Shared types and sizing for the serial receiver: FSM state encoding,
// default word width and the bit-counter width helper.
package receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_DATA_W);

  // A one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/rx_shift.sv
// LSB-first right-shift register with a running even-parity accumulator.
// Updates one cycle after shift_en; clr wins over shift_en; no backpressure.
module rx_shift
  import receiver_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] shift_dat,
  output logic [DATA_W-1:0] shift_nxt,
  output logic              par_acc
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  generate
    if (DATA_W == 1) begin : g_one
      assign shift_nxt = bit_in;
    end else begin : g_wide
      assign shift_nxt = {bit_in, shift_q[DATA_W-1:1]};
    end
  endgenerate

  always_comb begin
    shift_d = shift_q;
    par_d   = par_q;
    if (clr) begin
      shift_d = '0;
      par_d   = 1'b0;
    end else if (shift_en) begin
      shift_d = shift_nxt;
      par_d   = par_q ^ bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  assign shift_dat = shift_q;
  assign par_acc   = par_q;

endmodule

// File: rtl/receiver.sv
// Serial-to-parallel receiver: strobe-started frames, optional even parity,
// registered word held with valid/ack until consumed; overrun flags drops.
module receiver
  import receiver_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              wake_em_up,
  input  logic              data_ack,
  output logic [DATA_W-1:0] par_out,
  output logic              valid,
  output logic              par_err,
  output logic              overrun,
  output logic              ready
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] par_out_q, par_out_d;
  logic              valid_q, valid_d;
  logic              par_err_q, par_err_d;
  logic              overrun_q, overrun_d;

  logic              shift_clr;
  logic              shift_en;
  logic              frame_done;
  logic [DATA_W-1:0] shift_dat;
  logic [DATA_W-1:0] shift_nxt;
  logic              par_acc;
  logic [DATA_W-1:0] word_nxt;
  logic              err_nxt;

  rx_shift #(
    .DATA_W (DATA_W)
  ) u_rx_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (shift_clr),
    .shift_en  (shift_en),
    .bit_in    (serial_in),
    .shift_dat (shift_dat),
    .shift_nxt (shift_nxt),
    .par_acc   (par_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_clr  = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (wake_em_up) begin
          state_d   = DATA;
          cnt_d     = '0;
          shift_clr = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (PARITY_EN) begin
            state_d = PARITY;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      PARITY: begin
        state_d    = IDLE;
        frame_done = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Without parity the frame completes on the last data edge, so the word
  // is the shift register's next value rather than its current one.
  always_comb begin
    word_nxt = shift_nxt;
    err_nxt  = 1'b0;
    if (state_q == PARITY) begin
      word_nxt = shift_dat;
      err_nxt  = PARITY_EN & (par_acc ^ serial_in);
    end
  end

  always_comb begin
    par_out_d = par_out_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    overrun_d = overrun_q;
    if (frame_done && (!valid_q || data_ack)) begin
      par_out_d = word_nxt;
      par_err_d = err_nxt;
      valid_d   = 1'b1;
      if (valid_q) begin
        overrun_d = 1'b0;
      end
    end else if (frame_done) begin
      overrun_d = 1'b1;
    end else if (valid_q && data_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      par_out_q <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_out_q <= par_out_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign par_out = par_out_q;
  assign valid   = valid_q;
  assign par_err = par_err_q;
  assign overrun = overrun_q;
  assign ready   = (state_q == IDLE);

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver (DATA_W=8, PARITY_EN=1) with hand-computed
// expected words, parity errors, overrun and handshake behaviour.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       wake_em_up;
  logic       data_ack;
  logic [7:0] par_out;
  logic       valid;
  logic       par_err;
  logic       overrun;
  logic       ready;

  int n_cmp = 0;
  int n_err = 0;

  receiver #(
    .DATA_W    (8),
    .PARITY_EN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .wake_em_up (wake_em_up),
    .data_ack   (data_ack),
    .par_out    (par_out),
    .valid      (valid),
    .par_err    (par_err),
    .overrun    (overrun),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe, 8 data bits LSB-first, then the parity bit. wake_mask injects
  // stray strobes during data bits; ack_last raises data_ack on the
  // completion edge.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic ack_last, input logic [7:0] wake_mask);
    wake_em_up = 1'b1;
    serial_in  = 1'($urandom);
    tick();
    check("ready_low_after_strobe", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wake_em_up = wake_mask[i];
      serial_in  = d[i];
      tick();
    end
    check("ready_low_before_parity", {31'd0, ready}, 32'd0);
    wake_em_up = 1'b0;
    serial_in  = p;
    data_ack   = ack_last;
    tick();
    data_ack   = 1'b0;
    serial_in  = 1'b0;
    check("ready_high_after_frame", {31'd0, ready}, 32'd1);
  endtask

  task automatic ack_word();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    serial_in  = 1'b0;
    wake_em_up = 1'b0;
    data_ack   = 1'b0;
    tick();
    tick();
    check("rst_par_out", {24'd0, par_out}, 32'h00);
    check("rst_valid",   {31'd0, valid},   32'd0);
    check("rst_par_err", {31'd0, par_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_ready",   {31'd0, ready},   32'd1);

    // Leave a word pending, then reset in the middle of the next frame.
    rst = 1'b1;
    tick();
    send_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    wake_em_up = 1'b1;
    tick();
    wake_em_up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'b1;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_par_out", {24'd0, par_out}, 32'h00);
    check("midrst_valid",   {31'd0, valid},   32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    check("midrst_ready",   {31'd0, ready},   32'd1);
    tick();
    tick();
    send_frame(8'h81, 1'b0, 1'b0, 8'h00);
    check("post_rst_par_out", {24'd0, par_out}, 32'h81);
    check("post_rst_valid",   {31'd0, valid},   32'd1);
    check("post_rst_par_err", {31'd0, par_err}, 32'd0);
    ack_word();
    check("ack_clears_valid", {31'd0, valid}, 32'd0);
    check("ack_keeps_word",   {24'd0, par_out}, 32'h81);

    // 0x06 with good parity: valid exactly 9 cycles after the strobe.
    wake_em_up = 1'b1;
    tick();
    wake_em_up = 1'b0;
    for (int i = 0; i < 8; i++) begin
      serial_in = (i == 1 || i == 2);
      tick();
    end
    check("06_valid_not_early", {31'd0, valid}, 32'd0);
    serial_in = 1'b0;
    tick();
    check("06_valid",   {31'd0, valid},   32'd1);
    check("06_par_out", {24'd0, par_out}, 32'h06);
    check("06_par_err", {31'd0, par_err}, 32'd0);
    check("06_ready",   {31'd0, ready},   32'd1);
    ack_word();

    // Same word with a bad parity bit.
    send_frame(8'h06, 1'b1, 1'b0, 8'h00);
    check("06bad_par_out", {24'd0, par_out}, 32'h06);
    check("06bad_par_err", {31'd0, par_err}, 32'd1);
    check("06bad_valid",   {31'd0, valid},   32'd1);
    ack_word();
    check("06bad_acked", {31'd0, valid}, 32'd0);

    // Back-to-back frames with no ack: second word is dropped.
    send_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    check("a5_overrun_clear", {31'd0, overrun}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 8'h00);
    check("ovr_par_out", {24'd0, par_out}, 32'hA5);
    check("ovr_par_err", {31'd0, par_err}, 32'd0);
    check("ovr_overrun", {31'd0, overrun}, 32'd1);
    check("ovr_valid",   {31'd0, valid},   32'd1);
    ack_word();
    check("ovr_ack_valid",   {31'd0, valid},   32'd0);
    check("ovr_ack_overrun", {31'd0, overrun}, 32'd0);
    check("ovr_ack_par_out", {24'd0, par_out}, 32'hA5);

    // Completion coincides with the ack of the previous word.
    send_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b1, 8'h00);
    check("same_par_out", {24'd0, par_out}, 32'h3C);
    check("same_valid",   {31'd0, valid},   32'd1);
    check("same_overrun", {31'd0, overrun}, 32'd0);
    check("same_par_err", {31'd0, par_err}, 32'd0);
    ack_word();

    // Line noise in IDLE, then stray strobes during data bits.
    for (int i = 0; i < 12; i++) begin
      serial_in = 1'($urandom);
      tick();
    end
    serial_in = 1'b0;
    check("noise_valid", {31'd0, valid}, 32'd0);
    check("noise_ready", {31'd0, ready}, 32'd1);
    send_frame(8'hC3, 1'b0, 1'b0, 8'b0010_0101);
    check("stray_par_out", {24'd0, par_out}, 32'hC3);
    check("stray_par_err", {31'd0, par_err}, 32'd0);
    check("stray_valid",   {31'd0, valid},   32'd1);
    tick();
    check("stray_no_restart", {31'd0, ready}, 32'd1);
    check("stray_hold",       {24'd0, par_out}, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
